// File: rtl/w_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : w_input_conditioner
// Brief    : Conditions an asynchronous, bouncy raw_in into a clean level w
//            with single-cycle w_rise / w_fall strobes. A 2-flop synchronizer
//            feeds a 4-state debounce FSM (LOW, CHK_H, HIGH, CHK_L).
// Options  : define GLITCH_COUNT_EN to add the saturating glitch_count port,
//            which counts candidate transitions rejected during qualification.
// Revision : 1.0 - initial release
// ============================================================================
module w_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int GLITCH_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                raw_in,
    output logic                w,
    output logic                w_rise,
    output logic                w_fall,
    output logic                busy
`ifdef GLITCH_COUNT_EN
    ,
    output logic [GLITCH_W-1:0] glitch_count
`endif
);

    // A qualification length outside the counter's reach cannot be honoured.
    generate
        if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_bad_debounce
            $error("w_input_conditioner: DEBOUNCE_CYCLES out of range 1..2^CNT_W-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_LOW   = 2'd0,
        ST_CHK_H = 2'd1,
        ST_HIGH  = 2'd2,
        ST_CHK_L = 2'd3
    } state_t;

    // cnt holds samples already seen at the new level; reaching D-1 while the
    // next sample still agrees means D consecutive samples have been seen.
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               C_SINGLE   = (DEBOUNCE_CYCLES == 1);

    logic             s1_q;
    logic             s2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             w_q;
    logic             rise_q;
    logic             fall_q;
    logic             busy_q;

    // Two-flop synchronizer; the FSM only ever looks at s2_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_in;
            s2_q <= s1_q;
        end
    end

    // Debounce FSM with all outputs registered; strobes default low each cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
            w_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                ST_LOW: begin
                    if (s2_q) begin
                        if (C_SINGLE) begin
                            state_q <= ST_HIGH;
                            w_q     <= 1'b1;
                            rise_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_CHK_H;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_CHK_H: begin
                    if (!s2_q) begin
                        // Reversal: drop all credit and fall back to the stable level.
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        w_q     <= 1'b1;
                        rise_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_HIGH: begin
                    if (!s2_q) begin
                        if (C_SINGLE) begin
                            state_q <= ST_LOW;
                            w_q     <= 1'b0;
                            fall_q  <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= ST_CHK_L;
                            cnt_q   <= CNT_W'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_CHK_L: begin
                    if (s2_q) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == C_CNT_LAST) begin
                        state_q <= ST_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        w_q     <= 1'b0;
                        fall_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_LOW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    w_q     <= 1'b0;
                end
            endcase
        end
    end

    assign w      = w_q;
    assign w_rise = rise_q;
    assign w_fall = fall_q;
    assign busy   = busy_q;

`ifdef GLITCH_COUNT_EN
    logic                w_glitch;
    logic [GLITCH_W-1:0] gcnt_q;

    assign w_glitch = ((state_q == ST_CHK_H) && !s2_q) ||
                      ((state_q == ST_CHK_L) &&  s2_q);

    // Saturating count of rejected candidate transitions, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            gcnt_q <= '0;
        end else if (w_glitch && (gcnt_q != {GLITCH_W{1'b1}})) begin
            gcnt_q <= gcnt_q + GLITCH_W'(1);
        end
    end

    assign glitch_count = gcnt_q;
`endif

endmodule
`default_nettype wire
